bnn_fc_classifier: RTL and testbench
====================================

# bnn_fc_classifier

Binary fully-connected classifier stage that consumes the 154-bit binarized, max-pooled feature vector produced by the BWN convolution stage's output shift register. It scores NC classes by XNOR-popcount against 1-bit weight rows streamed from an external weight ROM, one class per clock. It tracks the running maximum and emits the winning class index and score with a single-cycle valid pulse.

## Interface

- BL, 154: feature vector / weight row length in bits
- NC, 10: number of classes (≥2)
- CW, 4: class index width, ≥ clog2(NC)
- SW, 9: signed score width; must hold ±BL

- iCLK  in  1  clock, rising edge
- iRST  in  1  reset, asynchronous, active-low
- iSTART  in  1  synchronous clear; when high, returns to IDLE and zeroes all outputs and state, same cycle priority over everything except iRST
- iDATA  in  BL  feature vector from the BWN shift register
- iVALID  in  1  iDATA valid; sampled only when oREADY=1
- oREADY  out  1  high in IDLE
- oW_RD  out  1  weight ROM read enable
- oW_ADDR  out  CW  weight row address (class index)
- iWEIGHT  in  BL  weight row; valid exactly one cycle after the oW_RD/oW_ADDR cycle
- oCLASS  out  CW  winning class index
- oSCORE  out  SW  winning score, signed
- oVALID  out  1  single-cycle result pulse

## Operation

- States: IDLE, RUN, DRAIN.
- IDLE: oREADY=1. iVALID=1 → latch iDATA into feature register, addr counter=0, go RUN.
- RUN: oW_RD=1, oW_ADDR=addr counter; counter increments each cycle. When oW_ADDR=NC-1 is issued, next state DRAIN.
- A 1-bit pipeline flag (rd_d) tracks oW_RD delayed one cycle, with index k_d = oW_ADDR delayed.
- When rd_d=1: match = ~(feature ^ iWEIGHT); pop = popcount(match), 0..BL; score = 2·pop − BL, sign-extended to SW.
- Best tracking, registered on the same edge: k_d=0 → best loaded unconditionally; k_d>0 → replace only if score > best (strict). On ties, the lower index wins.
- DRAIN: one cycle. The last score (k_d=NC-1) is compared. On that edge, oCLASS/oSCORE are loaded from the final best, oVALID is set, and the state returns to IDLE.
- oCLASS/oSCORE hold until the next result, iSTART, or reset.
- iVALID while oREADY=0 is ignored; there is no queueing.
- Popcount width is clog2(BL+1) unsigned. Score arithmetic must not overflow SW.

## Timing

- Reset (iRST=0, async) and iSTART (sync): state=IDLE, oREADY=1, oW_RD=0, oW_ADDR=0, oCLASS=0, oSCORE=0, oVALID=0, rd_d=0, best cleared.
- Accept at edge E0. oW_RD is high for cycles E0..E(NC), with addresses 0..NC-1.
- Class k is compared at edge E(k+2).
- oVALID is high for exactly the one cycle following edge E(NC+1). With NC=10, the pulse is 11 clocks after the accept edge.
- oREADY returns high in the same cycle as oVALID, so a new iVALID can be accepted on the edge ending the oVALID cycle.
- Throughput: one vector every NC+2 cycles.
- Reset or iSTART mid-RUN/DRAIN: the operation is aborted and no oVALID is produced. The next iVALID starts cleanly.
- iVALID and iSTART high together: iSTART wins and the vector is not accepted.

## Test plan

- Feature all-ones. Row 3 all-ones, other rows all-zeros. → oCLASS=3, oSCORE=+154, oVALID pulse 11 cycles after accept, oW_ADDR sequence 0..9.
- Feature all-zeros. All rows all-ones. → every score −154, oCLASS=0, oSCORE=−154.
- Rows 2 and 7 identical, both 100 matching bits; others 50 matching. → oCLASS=2, oSCORE=46.
- Hold iVALID high continuously. → accepts only in IDLE, one accept every 12 cycles, each with its own oVALID. Extra iVALID cycles are ignored.
- Drive iRST low during the RUN cycle at oW_ADDR=5. → all outputs zero immediately, no oVALID. A subsequent vector with the last row best gives oCLASS=9.
- Assert iSTART during DRAIN. → no oVALID, oCLASS/oSCORE=0, oREADY=1 next cycle.

Source files
------------

// File: rtl/bnn_fc_classifier.sv
// XNOR-popcount fully-connected classifier over binarized features.
// Scores one class per clock against streamed weight rows, keeps argmax.
module bnn_fc_classifier #(
  parameter int BL = 154,
  parameter int NC = 10,
  parameter int CW = 4,
  parameter int SW = 9
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iSTART,
  input  logic [BL-1:0]        iDATA,
  input  logic                 iVALID,
  output logic                 oREADY,
  output logic                 oW_RD,
  output logic [CW-1:0]        oW_ADDR,
  input  logic [BL-1:0]        iWEIGHT,
  output logic [CW-1:0]        oCLASS,
  output logic signed [SW-1:0] oSCORE,
  output logic                 oVALID
);

  localparam int PW = $clog2(BL + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [BL-1:0]         feat_q, feat_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rdp_q, rdp_d;
  logic [CW-1:0]         kd_q, kd_d;
  logic signed [SW-1:0]  best_q, best_d;
  logic [CW-1:0]         bidx_q, bidx_d;
  logic [CW-1:0]         cls_q, cls_d;
  logic signed [SW-1:0]  scr_q, scr_d;
  logic                  vld_q, vld_d;

  logic [BL-1:0]         match_w;
  logic [PW-1:0]         pop_w;
  logic signed [SW-1:0]  score_w;

  function automatic logic [PW-1:0] popcnt(
    input logic [BL-1:0] v
  );
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < BL; i++) begin
      c = c + PW'(v[i]);
    end
    return c;
  endfunction

  // 2*pop - BL is exact modulo 2^SW since the result fits
  assign match_w = ~(feat_q ^ iWEIGHT);
  assign pop_w   = popcnt(match_w);
  assign score_w = signed'(SW'({pop_w, 1'b0}) - SW'(BL));

  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    cnt_d   = cnt_q;
    rdp_d   = 1'b0;
    kd_d    = kd_q;
    best_d  = best_q;
    bidx_d  = bidx_q;
    cls_d   = cls_q;
    scr_d   = scr_q;
    vld_d   = 1'b0;

    if (rdp_q) begin
      if (kd_q == '0 || score_w > best_q) begin
        best_d = score_w;
        bidx_d = kd_q;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (iVALID) begin
          feat_d  = iDATA;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        rdp_d = 1'b1;
        kd_d  = cnt_q;
        if (cnt_q == CW'(NC - 1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        cls_d   = bidx_d;
        scr_d   = best_d;
        vld_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (iSTART) begin
      state_d = S_IDLE;
      feat_d  = '0;
      cnt_d   = '0;
      rdp_d   = 1'b0;
      kd_d    = '0;
      best_d  = '0;
      bidx_d  = '0;
      cls_d   = '0;
      scr_d   = '0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= S_IDLE;
      feat_q  <= '0;
      cnt_q   <= '0;
      rdp_q   <= 1'b0;
      kd_q    <= '0;
      best_q  <= '0;
      bidx_q  <= '0;
      cls_q   <= '0;
      scr_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      feat_q  <= feat_d;
      cnt_q   <= cnt_d;
      rdp_q   <= rdp_d;
      kd_q    <= kd_d;
      best_q  <= best_d;
      bidx_q  <= bidx_d;
      cls_q   <= cls_d;
      scr_q   <= scr_d;
      vld_q   <= vld_d;
    end
  end

  assign oREADY  = (state_q == S_IDLE);
  assign oW_RD   = (state_q == S_RUN);
  assign oW_ADDR = cnt_q;
  assign oCLASS  = cls_q;
  assign oSCORE  = scr_q;
  assign oVALID  = vld_q;

endmodule

// File: tb/tb_bnn_fc_classifier.sv
// Bench for bnn_fc_classifier: ROM model, argmax scoreboard, scenarios.
module tb_bnn_fc_classifier;

  localparam int BL = 154;
  localparam int NC = 10;
  localparam int CW = 4;
  localparam int SW = 9;

  logic                 iCLK;
  logic                 iRST;
  logic                 iSTART;
  logic [BL-1:0]        iDATA;
  logic                 iVALID;
  logic                 oREADY;
  logic                 oW_RD;
  logic [CW-1:0]        oW_ADDR;
  logic [BL-1:0]        iWEIGHT;
  logic [CW-1:0]        oCLASS;
  logic signed [SW-1:0] oSCORE;
  logic                 oVALID;

  bnn_fc_classifier #(
    .BL(BL), .NC(NC), .CW(CW), .SW(SW)
  ) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iSTART (iSTART),
    .iDATA  (iDATA),
    .iVALID (iVALID),
    .oREADY (oREADY),
    .oW_RD  (oW_RD),
    .oW_ADDR(oW_ADDR),
    .iWEIGHT(iWEIGHT),
    .oCLASS (oCLASS),
    .oSCORE (oSCORE),
    .oVALID (oVALID)
  );

  typedef struct {
    int     cls;
    int     scr;
    longint due;
  } exp_t;

  logic [BL-1:0] rows [NC];
  exp_t          q [$];
  longint        cyc;
  int            nvec;
  int            nerr;
  int            acc_cnt;

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  initial cyc = 0;
  always @(posedge iCLK) cyc++;

  // weight ROM: one cycle read latency
  always @(posedge iCLK) begin
    if (oW_RD) iWEIGHT <= rows[oW_ADDR];
  end

  function automatic void model(
    input  logic [BL-1:0] f,
    output int            cls,
    output int            scr
  );
    int pop;
    int s;
    cls = 0;
    scr = 0;
    for (int k = 0; k < NC; k++) begin
      pop = 0;
      for (int i = 0; i < BL; i++) begin
        if (f[i] == rows[k][i]) pop++;
      end
      s = 2 * pop - BL;
      if (k == 0 || s > scr) begin
        cls = k;
        scr = s;
      end
    end
  endfunction

  always @(negedge iCLK) begin
    exp_t e;
    if (iRST && !iSTART && iVALID && oREADY) begin
      model(iDATA, e.cls, e.scr);
      e.due = cyc + 12;
      q.push_back(e);
      acc_cnt++;
    end
    if (oVALID) begin
      nvec++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_ovalid cyc=%0d cls=%0d",
                 cyc, oCLASS);
      end else begin
        e = q.pop_front();
        if (oCLASS !== CW'(e.cls) ||
            oSCORE !== SW'(e.scr) ||
            cyc !== e.due) begin
          nerr++;
          $display("FAIL result got cls=%0d scr=%0d cyc=%0d want cls=%0d scr=%0d cyc=%0d",
                   oCLASS, oSCORE, cyc, e.cls, e.scr, e.due);
        end
      end
    end else if (q.size() != 0 && cyc > q[0].due) begin
      nvec++;
      nerr++;
      $display("FAIL missing_ovalid cyc=%0d due=%0d", cyc, q[0].due);
      void'(q.pop_front());
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL timeout pending=%0d want 0", q.size());
      q.delete();
    end
  endtask

  function automatic logic [BL-1:0] rnd_vec();
    logic [BL-1:0] v;
    for (int i = 0; i < BL; i++) v[i] = 1'($urandom_range(1, 0));
    return v;
  endfunction

  task automatic test_reset();
    iRST = 1'b1;
    #1 iRST = 1'b0;
    #1;
    nvec++;
    if (oREADY !== 1'b1 || oW_RD !== 1'b0 ||
        oW_ADDR !== '0 || oCLASS !== '0 ||
        oSCORE !== '0 || oVALID !== 1'b0) begin
      nerr++;
      $display("FAIL reset rdy=%b rd=%b a=%0d c=%0d s=%0d v=%b want 1 0 0 0 0 0",
               oREADY, oW_RD, oW_ADDR, oCLASS, oSCORE, oVALID);
    end
    tick();
    tick();
    iRST = 1'b1;
    tick();
  endtask

  task automatic test_one_hot_row();
    iDATA = '1;
    for (int k = 0; k < NC; k++) rows[k] = '0;
    rows[3] = '1;
    iVALID = 1'b1;
    tick();
    iVALID = 1'b0;
    for (int i = 0; i < NC; i++) begin
      nvec++;
      if (oW_RD !== 1'b1 || oW_ADDR !== CW'(i)) begin
        nerr++;
        $display("FAIL addr_seq rd=%b a=%0d want 1 %0d",
                 oW_RD, oW_ADDR, i);
      end
      tick();
    end
    nvec++;
    if (oW_RD !== 1'b0 || oREADY !== 1'b0) begin
      nerr++;
      $display("FAIL drain rd=%b rdy=%b want 0 0", oW_RD, oREADY);
    end
    wait_done();
    nvec++;
    if (oCLASS !== 4'd3 || oSCORE !== 9'sd154) begin
      nerr++;
      $display("FAIL one_hot cls=%0d scr=%0d want 3 154",
               oCLASS, oSCORE);
    end
  endtask

  task automatic test_all_negative();
    iDATA = '0;
    for (int k = 0; k < NC; k++) rows[k] = '1;
    iVALID = 1'b1;
    tick();
    iVALID = 1'b0;
    wait_done();
    nvec++;
    if (oCLASS !== 4'd0 || oSCORE !== -9'sd154) begin
      nerr++;
      $display("FAIL all_neg cls=%0d scr=%0d want 0 -154",
               oCLASS, oSCORE);
    end
  endtask

  task automatic test_tie();
    logic [BL-1:0] f;
    logic [BL-1:0] m54;
    logic [BL-1:0] m104;
    f    = rnd_vec();
    m54  = '0;
    m104 = '0;
    for (int i = 0; i < 54; i++) m54[i] = 1'b1;
    for (int i = 0; i < 104; i++) m104[BL-1-i] = 1'b1;
    for (int k = 0; k < NC; k++) rows[k] = f ^ m104;
    rows[2] = f ^ m54;
    rows[7] = f ^ m54;
    iDATA  = f;
    iVALID = 1'b1;
    tick();
    iVALID = 1'b0;
    wait_done();
    nvec++;
    if (oCLASS !== 4'd2 || oSCORE !== 9'sd46) begin
      nerr++;
      $display("FAIL tie cls=%0d scr=%0d want 2 46",
               oCLASS, oSCORE);
    end
  endtask

  task automatic test_hold_valid();
    int a0;
    for (int k = 0; k < NC; k++) rows[k] = rnd_vec();
    iDATA  = rnd_vec();
    a0     = acc_cnt;
    iVALID = 1'b1;
    repeat (36) tick();
    iVALID = 1'b0;
    nvec++;
    if (acc_cnt - a0 !== 3) begin
      nerr++;
      $display("FAIL hold_accepts got %0d want 3", acc_cnt - a0);
    end
    wait_done();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NC; k++) rows[k] = rnd_vec();
    for (int n = 0; n < 3; n++) begin
      iDATA  = rnd_vec();
      iVALID = 1'b1;
      tick();
      iVALID = 1'b0;
      repeat (11) tick();
    end
    wait_done();
  endtask

  task automatic test_reset_abort();
    int guard;
    logic [BL-1:0] f;
    f = rnd_vec();
    for (int k = 0; k < NC; k++) rows[k] = f ^ rnd_vec() ^ {BL{1'b1}};
    rows[NC-1] = f;
    iDATA  = f;
    iVALID = 1'b1;
    tick();
    iVALID = 1'b0;
    guard = 0;
    while (!(oW_RD === 1'b1 && oW_ADDR === 4'd5) && guard < 20) begin
      tick();
      guard++;
    end
    iRST = 1'b0;
    q.delete();
    #1;
    nvec++;
    if (guard >= 20 || oW_RD !== 1'b0 || oW_ADDR !== '0 ||
        oCLASS !== '0 || oSCORE !== '0 ||
        oVALID !== 1'b0 || oREADY !== 1'b1) begin
      nerr++;
      $display("FAIL rst_abort g=%0d rd=%b a=%0d c=%0d s=%0d v=%b want 0 0 0 0 0",
               guard, oW_RD, oW_ADDR, oCLASS, oSCORE, oVALID);
    end
    tick();
    iRST = 1'b1;
    repeat (15) tick();
    iVALID = 1'b1;
    tick();
    iVALID = 1'b0;
    wait_done();
    nvec++;
    if (oCLASS !== 4'd9 || oSCORE !== 9'sd154) begin
      nerr++;
      $display("FAIL after_rst cls=%0d scr=%0d want 9 154",
               oCLASS, oSCORE);
    end
  endtask

  task automatic test_start_drain();
    int guard;
    iVALID = 1'b1;
    tick();
    iVALID = 1'b0;
    guard = 0;
    while (!(oW_RD === 1'b0 && oREADY === 1'b0) && guard < 20) begin
      tick();
      guard++;
    end
    iSTART = 1'b1;
    q.delete();
    tick();
    iSTART = 1'b0;
    nvec++;
    if (guard >= 20 || oREADY !== 1'b1 || oVALID !== 1'b0 ||
        oCLASS !== '0 || oSCORE !== '0) begin
      nerr++;
      $display("FAIL start_drain g=%0d rdy=%b v=%b c=%0d s=%0d want 1 0 0 0",
               guard, oREADY, oVALID, oCLASS, oSCORE);
    end
    repeat (15) tick();
  endtask

  task automatic test_start_beats_valid();
    iVALID = 1'b1;
    iSTART = 1'b1;
    tick();
    iVALID = 1'b0;
    iSTART = 1'b0;
    nvec++;
    if (oREADY !== 1'b1 || oW_RD !== 1'b0) begin
      nerr++;
      $display("FAIL start_vs_valid rdy=%b rd=%b want 1 0",
               oREADY, oW_RD);
    end
    repeat (15) tick();
  endtask

  initial begin
    nvec    = 0;
    nerr    = 0;
    acc_cnt = 0;
    iSTART  = 1'b0;
    iVALID  = 1'b0;
    iDATA   = '0;
    iWEIGHT = '0;
    for (int k = 0; k < NC; k++) rows[k] = '0;
    test_reset();
    test_one_hot_row();
    test_all_negative();
    test_tie();
    test_hold_valid();
    test_back_to_back();
    test_reset_abort();
    test_start_drain();
    test_start_beats_valid();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
